// File: rtl/vga_timing_ctrl.sv
// Raster sequencer: h/v counters, sync generation, pixel/line/frame strobes, shadowed mode registers.
// Latency: all outputs registered and mutually aligned with o_hpos/o_vpos; mode takes effect on the first cycle of a frame.
// Backpressure: none; free-running while i_en=1. Optional macro VGA_TIMING_POLARITY_EN adds programmable sync polarity.
module vga_timing_ctrl #(
    parameter int          HW          = 12,
    parameter int          VW          = 12,
    parameter int unsigned RST_H_WIDTH = 640,
    parameter int unsigned RST_H_PORCH = 656,
    parameter int unsigned RST_H_SYNCH = 752,
    parameter int unsigned RST_H_RAW   = 800,
    parameter int unsigned RST_V_WIDTH = 480,
    parameter int unsigned RST_V_PORCH = 490,
    parameter int unsigned RST_V_SYNCH = 492,
    parameter int unsigned RST_V_RAW   = 525
) (
    input  logic          i_pixclk,
    input  logic          i_reset_n,
    input  logic          i_en,
    input  logic [HW-1:0] i_hm_width,
    input  logic [HW-1:0] i_hm_porch,
    input  logic [HW-1:0] i_hm_synch,
    input  logic [HW-1:0] i_hm_raw,
    input  logic [VW-1:0] i_vm_height,
    input  logic [VW-1:0] i_vm_porch,
    input  logic [VW-1:0] i_vm_synch,
    input  logic [VW-1:0] i_vm_raw,
`ifdef VGA_TIMING_POLARITY_EN
    input  logic          i_hpol,
    input  logic          i_vpol,
`endif
    output logic          o_rd,
    output logic          o_newline,
    output logic          o_newframe,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic [HW-1:0] o_hpos,
    output logic [VW-1:0] o_vpos,
    output logic          o_err
);

    // Per-axis raster regions, decoded from the position counter.
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    function automatic logic [1:0] h_region(input logic [HW-1:0] pos, input logic [HW-1:0] wd,
                                            input logic [HW-1:0] po, input logic [HW-1:0] sy);
        if (pos < wd)      return ST_ACTIVE;
        else if (pos < po) return ST_FRONT;
        else if (pos < sy) return ST_SYNC;
        else               return ST_BACK;
    endfunction

    function automatic logic [1:0] v_region(input logic [VW-1:0] pos, input logic [VW-1:0] wd,
                                            input logic [VW-1:0] po, input logic [VW-1:0] sy);
        if (pos < wd)      return ST_ACTIVE;
        else if (pos < po) return ST_FRONT;
        else if (pos < sy) return ST_SYNC;
        else               return ST_BACK;
    endfunction

    // Shadow (in-use) mode
    logic [HW-1:0] r_h_width, r_h_porch, r_h_synch, r_h_raw;
    logic [VW-1:0] r_v_height, r_v_porch, r_v_synch, r_v_raw;
    logic          r_hpol, r_vpol;

    // Raster state and registered outputs
    logic          r_run;
    logic [HW-1:0] r_hpos;
    logic [VW-1:0] r_vpos;
    logic          r_rd, r_newline, r_newframe, r_hsync, r_vsync, r_err;

    logic          w_hpol_in, w_vpol_in;
    logic          w_mode_ok, w_load, w_take;
    logic [HW-1:0] w_h_width_n, w_h_porch_n, w_h_synch_n, w_h_raw_n;
    logic [VW-1:0] w_v_height_n, w_v_porch_n, w_v_synch_n, w_v_raw_n;
    logic          w_hpol_n, w_vpol_n;
    logic [HW-1:0] w_hpos_n;
    logic [VW-1:0] w_vpos_n;
    logic [1:0]    w_hstate_n, w_vstate_n;
    logic          w_rd_n, w_newline_n, w_newframe_n, w_hsync_n, w_vsync_n;

`ifdef VGA_TIMING_POLARITY_EN
    assign w_hpol_in = i_hpol;
    assign w_vpol_in = i_vpol;
`else
    assign w_hpol_in = 1'b0;
    assign w_vpol_in = 1'b0;
`endif

    // Mode validity and next shadow mode: loads at frame end, or continuously while disabled
    always_comb begin
        w_mode_ok = (i_hm_width  < i_hm_porch) && (i_hm_porch < i_hm_synch) && (i_hm_synch < i_hm_raw) &&
                    (i_vm_height < i_vm_porch) && (i_vm_porch < i_vm_synch) && (i_vm_synch < i_vm_raw);
        w_load    = !i_en || r_newframe;
        w_take    = w_load && w_mode_ok;
        w_h_width_n  = w_take ? i_hm_width  : r_h_width;
        w_h_porch_n  = w_take ? i_hm_porch  : r_h_porch;
        w_h_synch_n  = w_take ? i_hm_synch  : r_h_synch;
        w_h_raw_n    = w_take ? i_hm_raw    : r_h_raw;
        w_v_height_n = w_take ? i_vm_height : r_v_height;
        w_v_porch_n  = w_take ? i_vm_porch  : r_v_porch;
        w_v_synch_n  = w_take ? i_vm_synch  : r_v_synch;
        w_v_raw_n    = w_take ? i_vm_raw    : r_v_raw;
        w_hpol_n     = w_take ? w_hpol_in   : r_hpol;
        w_vpol_n     = w_take ? w_vpol_in   : r_vpol;
    end

    // Next position and next outputs, evaluated against the mode that will be in force next cycle
    always_comb begin
        w_hpos_n = '0;
        w_vpos_n = '0;
        if (i_en && r_run) begin
            if (r_newline) begin
                w_hpos_n = '0;
                w_vpos_n = r_newframe ? '0 : r_vpos + VW'(1);
            end else begin
                w_hpos_n = r_hpos + HW'(1);
                w_vpos_n = r_vpos;
            end
        end
        w_hstate_n    = h_region(w_hpos_n, w_h_width_n, w_h_porch_n, w_h_synch_n);
        w_vstate_n    = v_region(w_vpos_n, w_v_height_n, w_v_porch_n, w_v_synch_n);
        w_rd_n        = i_en && (w_hstate_n == ST_ACTIVE) && (w_vstate_n == ST_ACTIVE);
        w_newline_n   = i_en && (w_hpos_n == w_h_raw_n - HW'(1));
        w_newframe_n  = w_newline_n && (w_vpos_n == w_v_raw_n - VW'(1));
        w_hsync_n     = (i_en && (w_hstate_n == ST_SYNC)) ? w_hpol_n : !w_hpol_n;
        w_vsync_n     = (i_en && (w_vstate_n == ST_SYNC)) ? w_vpol_n : !w_vpol_n;
    end

    // Shadow mode registers
    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            r_h_width  <= HW'(RST_H_WIDTH);
            r_h_porch  <= HW'(RST_H_PORCH);
            r_h_synch  <= HW'(RST_H_SYNCH);
            r_h_raw    <= HW'(RST_H_RAW);
            r_v_height <= VW'(RST_V_WIDTH);
            r_v_porch  <= VW'(RST_V_PORCH);
            r_v_synch  <= VW'(RST_V_SYNCH);
            r_v_raw    <= VW'(RST_V_RAW);
            r_hpol     <= 1'b0;
            r_vpol     <= 1'b0;
        end else begin
            r_h_width  <= w_h_width_n;
            r_h_porch  <= w_h_porch_n;
            r_h_synch  <= w_h_synch_n;
            r_h_raw    <= w_h_raw_n;
            r_v_height <= w_v_height_n;
            r_v_porch  <= w_v_porch_n;
            r_v_synch  <= w_v_synch_n;
            r_v_raw    <= w_v_raw_n;
            r_hpol     <= w_hpol_n;
            r_vpol     <= w_vpol_n;
        end
    end

    // Sticky error: an invalid mode was offered at a load point
    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) r_err <= 1'b0;
        else if (w_load && !w_mode_ok) r_err <= 1'b1;
    end

    // Counters and registered raster outputs
    always_ff @(posedge i_pixclk) begin
        if (!i_reset_n) begin
            r_run      <= 1'b0;
            r_hpos     <= '0;
            r_vpos     <= '0;
            r_rd       <= 1'b0;
            r_newline  <= 1'b0;
            r_newframe <= 1'b0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
        end else begin
            r_run      <= i_en;
            r_hpos     <= w_hpos_n;
            r_vpos     <= w_vpos_n;
            r_rd       <= w_rd_n;
            r_newline  <= w_newline_n;
            r_newframe <= w_newframe_n;
            r_hsync    <= w_hsync_n;
            r_vsync    <= w_vsync_n;
        end
    end

    assign o_rd       = r_rd;
    assign o_newline  = r_newline;
    assign o_newframe = r_newframe;
    assign o_hsync    = r_hsync;
    assign o_vsync    = r_vsync;
    assign o_hpos     = r_hpos;
    assign o_vpos     = r_vpos;
    assign o_err      = r_err;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: table of modes, corner-case sequences and a randomized run.
// Reference model tracks a linear pixel index per frame and derives position/regions arithmetically.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_vga_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [11:0] hw, hp, hs, hr, vh, vp, vs, vr;
    logic        hpol, vpol;
    logic        o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_err;
    logic [11:0] o_hpos, o_vpos;

    always #5 clk = ~clk;

    vga_timing_ctrl dut (
        .i_pixclk(clk), .i_reset_n(rst_n), .i_en(en),
        .i_hm_width(hw), .i_hm_porch(hp), .i_hm_synch(hs), .i_hm_raw(hr),
        .i_vm_height(vh), .i_vm_porch(vp), .i_vm_synch(vs), .i_vm_raw(vr),
`ifdef VGA_TIMING_POLARITY_EN
        .i_hpol(hpol), .i_vpol(vpol),
`endif
        .o_rd(o_rd), .o_newline(o_newline), .o_newframe(o_newframe),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_hpos(o_hpos), .o_vpos(o_vpos), .o_err(o_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_run, m_err, m_hpol, m_vpol;
    int m_idx;
    int mh[4];
    int mv[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ordered(input int a, input int b, input int c, input int d);
        return (a < b) && (b < c) && (c < d);
    endfunction

    task automatic model_step();
        bit frame_end, load;
        int nidx;
        if (!rst_n) begin
            m_run = 0; m_idx = 0; m_err = 0; m_hpol = 0; m_vpol = 0;
            mh = '{640, 656, 752, 800};
            mv = '{480, 490, 492, 525};
        end else begin
            frame_end = m_run && (m_idx == mh[3] * mv[3] - 1);
            load      = !en || frame_end;
            nidx      = (en && m_run) ? (frame_end ? 0 : m_idx + 1) : 0;
            if (load) begin
                if (ordered(int'(hw), int'(hp), int'(hs), int'(hr)) &&
                    ordered(int'(vh), int'(vp), int'(vs), int'(vr))) begin
                    mh = '{int'(hw), int'(hp), int'(hs), int'(hr)};
                    mv = '{int'(vh), int'(vp), int'(vs), int'(vr)};
                    m_hpol = hpol; m_vpol = vpol;
                end else begin
                    m_err = 1;
                end
            end
            m_run = en;
            m_idx = nidx;
        end
    endtask

    task automatic check_outputs();
        int h, v;
        bit e_rd, e_nl, e_nf, e_hs, e_vs;
        logic [29:0] a, e;
        h = 0; v = 0; e_rd = 0; e_nl = 0; e_nf = 0;
        e_hs = !m_hpol; e_vs = !m_vpol;
        if (m_run) begin
            h    = m_idx % mh[3];
            v    = m_idx / mh[3];
            e_rd = (h < mh[0]) && (v < mv[0]);
            e_nl = (h == mh[3] - 1);
            e_nf = (m_idx == mh[3] * mv[3] - 1);
            e_hs = (h >= mh[1] && h < mh[2]) ? m_hpol : !m_hpol;
            e_vs = (v >= mv[1] && v < mv[2]) ? m_vpol : !m_vpol;
        end
        a = {o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_err, o_hpos, o_vpos};
        e = {e_rd, e_nl, e_nf, e_hs, e_vs, m_err, 12'(h), 12'(v)};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model {rd,nl,nf,hs,vs,err,hpos,vpos}: actual=%h required=%h at t=%0t", a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic set_mode(input int a, input int b, input int c, input int d,
                            input int e, input int f, input int g, input int k);
        hw = 12'(a); hp = 12'(b); hs = 12'(c); hr = 12'(d);
        vh = 12'(e); vp = 12'(f); vs = 12'(g); vr = 12'(k);
    endtask

    typedef struct {
        int h0, h1, h2, h3, v0, v1, v2, v3;
        int exp_err, exp_frame, exp_rd, exp_lines, exp_hlow, exp_vlow;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rdc, nlc, hlow, vlow, first_low, last_low, r;

        tbl[0] = '{8, 10, 12, 14, 4, 5, 6, 7,        0, 98, 32, 7, 14, 14};
        tbl[1] = '{4, 5, 9, 10, 2, 3, 4, 5,          0, 50, 8, 5, 20, 10};
        tbl[2] = '{1, 2, 3, 4, 1, 2, 3, 4,           0, 16, 1, 4, 4, 4};
        tbl[3] = '{6, 6, 8, 10, 2, 3, 4, 5,          1, 16, 1, 4, 4, 4};
        tbl[4] = '{16, 20, 24, 30, 3, 4, 6, 8,       1, 240, 48, 8, 32, 60};
        tbl[5] = '{16, 20, 24, 0, 3, 4, 6, 8,        1, 240, 48, 8, 32, 60};

        rst_n = 0; en = 0; hpol = 0; vpol = 0;
        set_mode(640, 656, 752, 800, 480, 490, 492, 525);
        tick(); tick();
        chk("reset_hpos", int'(o_hpos), 0);
        chk("reset_rd", int'(o_rd), 0);
        chk("reset_hsync", int'(o_hsync), 1);
        chk("reset_vsync", int'(o_vsync), 1);
        chk("reset_err", int'(o_err), 0);

        // Default mode: one full line
        rst_n = 1; en = 1;
        tick();
        n = 0; rdc = 0; hlow = 0; first_low = -1; last_low = -1;
        for (int i = 0; i < 1000; i++) begin
            n++;
            if (!o_hsync) begin
                hlow++;
                if (first_low < 0) first_low = int'(o_hpos);
                last_low = int'(o_hpos);
            end
            if (o_rd) rdc++;
            if (o_newline) break;
            tick();
        end
        chk("line_clocks", n, 800);
        chk("line_rd", rdc, 640);
        chk("hsync_low_clocks", hlow, 96);
        chk("hsync_first_low", first_low, 656);
        chk("hsync_last_low", last_low, 751);
        tick();
        chk("line1_vpos", int'(o_vpos), 1);
        chk("line1_hpos", int'(o_hpos), 0);

        // Enable dropped mid-line, then restored
        for (int i = 0; i < 1000 && o_hpos != 12'd100; i++) tick();
        chk("reach_hpos100", int'(o_hpos), 100);
        en = 0;
        tick();
        chk("drop_rd", int'(o_rd), 0);
        chk("drop_hpos", int'(o_hpos), 0);
        nlc = 0;
        for (int i = 0; i < 800; i++) begin
            if (o_newline) nlc++;
            tick();
        end
        chk("drop_newlines", nlc, 0);
        en = 1;
        tick();
        chk("reen_hpos", int'(o_hpos), 0);
        chk("reen_vpos", int'(o_vpos), 0);
        chk("reen_rd", int'(o_rd), 1);

        // Table of modes, each measured over one frame
        for (int t = 0; t < 6; t++) begin
            set_mode(tbl[t].h0, tbl[t].h1, tbl[t].h2, tbl[t].h3, tbl[t].v0, tbl[t].v1, tbl[t].v2, tbl[t].v3);
            en = 0;
            tick(); tick();
            en = 1;
            tick();
            n = 0; rdc = 0; nlc = 0; hlow = 0; vlow = 0;
            for (int i = 0; i < 2000; i++) begin
                n++;
                if (o_rd) rdc++;
                if (o_newline) nlc++;
                if (!o_hsync) hlow++;
                if (!o_vsync) vlow++;
                if (o_newframe) break;
                tick();
            end
            chk($sformatf("tbl%0d_frame", t), n, tbl[t].exp_frame);
            chk($sformatf("tbl%0d_rd", t), rdc, tbl[t].exp_rd);
            chk($sformatf("tbl%0d_lines", t), nlc, tbl[t].exp_lines);
            chk($sformatf("tbl%0d_hlow", t), hlow, tbl[t].exp_hlow);
            chk($sformatf("tbl%0d_vlow", t), vlow, tbl[t].exp_vlow);
            chk($sformatf("tbl%0d_err", t), int'(o_err), tbl[t].exp_err);
        end

        // Mid-frame mode write only takes effect after the frame ends
        set_mode(8, 10, 12, 14, 4, 5, 6, 7);
        en = 0;
        tick();
        en = 1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        set_mode(4, 5, 9, 10, 2, 3, 4, 5);
        n = 0; nlc = 0;
        for (int i = 0; i < 500; i++) begin
            n++;
            if (o_newline) nlc++;
            if (o_newframe) break;
            tick();
        end
        chk("midwrite_rest_of_frame", n, 78);
        chk("midwrite_newlines", nlc, 6);
        tick();
        chk("newmode_hpos", int'(o_hpos), 0);
        chk("newmode_vpos", int'(o_vpos), 0);
        n = 0; rdc = 0;
        for (int i = 0; i < 500; i++) begin
            n++;
            if (o_rd) rdc++;
            if (o_newline) break;
            tick();
        end
        chk("newmode_line_clocks", n, 10);
        chk("newmode_line_rd", rdc, 4);

        // Reset mid-line while enabled clears position and the sticky error
        for (int i = 0; i < 3; i++) tick();
        rst_n = 0;
        tick();
        chk("midreset_hpos", int'(o_hpos), 0);
        chk("midreset_vpos", int'(o_vpos), 0);
        chk("midreset_rd", int'(o_rd), 0);
        chk("midreset_hsync", int'(o_hsync), 1);
        chk("midreset_vsync", int'(o_vsync), 1);
        chk("midreset_err", int'(o_err), 0);
        rst_n = 1;

`ifdef VGA_TIMING_POLARITY_EN
        // Positive horizontal sync on the default mode
        set_mode(640, 656, 752, 800, 480, 490, 492, 525);
        hpol = 1; en = 0;
        tick();
        en = 1;
        tick();
        hlow = 0; first_low = -1;
        for (int i = 0; i < 1000; i++) begin
            if (o_hsync) begin
                hlow++;
                if (first_low < 0) first_low = int'(o_hpos);
            end
            if (o_newline) break;
            tick();
        end
        chk("pol_hsync_high_clocks", hlow, 96);
        chk("pol_hsync_first_high", first_low, 656);
        hpol = 0;
`endif

        // Randomized run against the model
        set_mode(8, 10, 12, 14, 4, 5, 6, 7);
        en = 1;
        for (int i = 0; i < 20000; i++) begin
            r = int'($urandom_range(0, 999));
            rst_n = (r < 2) ? 1'b0 : 1'b1;
            if (r >= 2 && r < 7) en = ~en;
            if (r >= 10 && r < 40) begin
                if ($urandom_range(0, 9) == 0) begin
                    set_mode(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end else begin
                    hw = 12'($urandom_range(1, 6));
                    hp = hw + 12'($urandom_range(1, 3));
                    hs = hp + 12'($urandom_range(1, 3));
                    hr = hs + 12'($urandom_range(1, 3));
                    vh = 12'($urandom_range(1, 4));
                    vp = vh + 12'($urandom_range(1, 2));
                    vs = vp + 12'($urandom_range(1, 2));
                    vr = vs + 12'($urandom_range(1, 2));
                end
`ifdef VGA_TIMING_POLARITY_EN
                hpol = 1'($urandom_range(0, 1));
                vpol = 1'($urandom_range(0, 1));
`endif
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
